// File: rtl/upc_mon_pkg.sv
// -----------------------------------------------------------------------------
// upc_mon_pkg
// Shared definitions for the loop/handshake performance monitor:
//   - default parameter constants (state encoding width, counter width)
//   - state enums for the module handshake FSM and the loop FSM
// Optional feature macro used by the monitor: UPC_MON_STALL_CNT_EN.
// -----------------------------------------------------------------------------
package upc_mon_pkg;

   localparam int DEF_STATE_W = 3;
   localparam int DEF_CNT_W   = 32;

   // Module-level handshake tracker.
   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mod_state_e;

   // Loop tracker.
   typedef enum logic {
      LIDLE = 1'b0,
      LRUN  = 1'b1
   } loop_state_e;

endpackage : upc_mon_pkg

// File: rtl/upc_sat_counter.sv
// -----------------------------------------------------------------------------
// upc_sat_counter
// Saturating up-counter used for every statistic of the monitor.
// Ports:
//   clock  - rising-edge clock
//   reset  - synchronous active-high clear (wins over inc and hold)
//   inc    - add one this cycle
//   hold   - freeze the count (inc ignored)
//   count  - registered count, sticks at 2^CNT_W-1
// -----------------------------------------------------------------------------
module upc_sat_counter
   import upc_mon_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inc,
   input  logic             hold,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      count_d = count_q;
      if (inc && !hold && (count_q != CNT_MAX)) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   // NOTE: registers are written only with non-blocking assignments so all
   // flops sample the same pre-edge values regardless of block ordering.
   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule : upc_sat_counter

// File: rtl/upc_loop_monitor.sv
// -----------------------------------------------------------------------------
// upc_loop_monitor
// Passive monitor for a module's ap_* handshake and one pipelined loop inside
// it. Counts transactions, busy cycles, latency of the last transaction,
// loop iterations started/ended and completed loops. All counters saturate.
// A 'finish' pulse freezes everything until the next reset.
//
// Ports:
//   clock, reset                  - single clock, synchronous active-high reset
//   finish                        - end of observation, sticky freeze
//   ap_start/ready/done/continue  - observed module handshake
//   cur_state, *_state            - loop FSM state and reference states
//   *_block, *_enable             - stage subdone-block flags / pipeline enables
//   loop_start/ready/done/continue, quit_at_end - loop handshake
//   txn_cnt, busy_cyc, last_latency, iter_start_cnt, iter_end_cnt, loop_cnt
//                                 - statistics (CNT_W bits)
//   mod_busy, loop_active, frozen - registered status flags
//   stall_cyc                     - LRUN cycles with a stage blocked
//                                   (only with UPC_MON_STALL_CNT_EN defined)
// -----------------------------------------------------------------------------
module upc_loop_monitor
   import upc_mon_pkg::*;
#(
   parameter int STATE_W = DEF_STATE_W,
   parameter int CNT_W   = DEF_CNT_W
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               finish,
   input  logic               ap_start,
   input  logic               ap_ready,
   input  logic               ap_done,
   input  logic               ap_continue,
   input  logic [STATE_W-1:0] cur_state,
   input  logic [STATE_W-1:0] iter_start_state,
   input  logic [STATE_W-1:0] iter_end_state,
   input  logic [STATE_W-1:0] quit_state,
   input  logic               iter_start_block,
   input  logic               iter_end_block,
   input  logic               quit_block,
   input  logic               iter_start_enable,
   input  logic               iter_end_enable,
   input  logic               quit_enable,
   input  logic               loop_start,
   input  logic               loop_ready,
   input  logic               loop_done,
   input  logic               loop_continue,
   input  logic               quit_at_end,
   output logic [CNT_W-1:0]   txn_cnt,
   output logic [CNT_W-1:0]   busy_cyc,
   output logic [CNT_W-1:0]   last_latency,
   output logic [CNT_W-1:0]   iter_start_cnt,
   output logic [CNT_W-1:0]   iter_end_cnt,
   output logic [CNT_W-1:0]   loop_cnt,
`ifdef UPC_MON_STALL_CNT_EN
   output logic [CNT_W-1:0]   stall_cyc,
`endif
   output logic               mod_busy,
   output logic               loop_active,
   output logic               frozen
);

   mod_state_e       mod_state_q,  mod_state_d;
   loop_state_e      loop_state_q, loop_state_d;
   logic [CNT_W-1:0] last_latency_q, last_latency_d;
   logic             frozen_q, frozen_d;

   logic             hold;
   logic             start_acc;
   logic             txn_done;
   logic             busy_now;
   logic             loop_go;
   logic             iter_start_ev;
   logic             iter_end_ev;
   logic             quit_ev;
   logic             loop_end;
   logic             lat_clr;
   logic [CNT_W-1:0] lat_cnt;
   logic [CNT_W:0]   lat_sum;

   // Handshake observation only; these never influence state.
   logic unused_inputs;
   assign unused_inputs = ap_ready ^ loop_ready;

   // The edge that samples finish is already frozen, so activity in the
   // finish cycle itself is not recorded.
   assign hold = frozen_q | finish;

   // ---------------------------------------------------------------- events
   // In LIDLE the loop_start cycle already qualifies, so an iteration that
   // starts in the very first loop cycle is not lost.
   assign loop_go       = (loop_state_q == LRUN) || loop_start;
   assign iter_start_ev = (cur_state == iter_start_state) && !iter_start_block
                          && iter_start_enable && loop_go;
   assign iter_end_ev   = (cur_state == iter_end_state) && !iter_end_block
                          && iter_end_enable && loop_go;
   assign quit_ev       = (cur_state == quit_state) && !quit_block
                          && quit_enable && quit_at_end && loop_go;

   // Latency = in-flight counter + start cycle + done cycle, clamped.
   assign lat_sum = {1'b0, lat_cnt} + (CNT_W+1)'(2);

   // ------------------------------------------------------ next-state logic
   always_comb begin
      mod_state_d    = mod_state_q;
      loop_state_d   = loop_state_q;
      last_latency_d = last_latency_q;
      frozen_d       = frozen_q | finish;
      start_acc      = 1'b0;
      txn_done       = 1'b0;
      loop_end       = 1'b0;

      case (mod_state_q)
         IDLE: begin
            if (ap_start) begin
               start_acc   = 1'b1;
               mod_state_d = BUSY;
            end
         end
         BUSY: begin
            if (ap_done && ap_continue) begin
               txn_done       = 1'b1;
               last_latency_d = lat_sum[CNT_W] ? '1 : lat_sum[CNT_W-1:0];
               // A start in the done cycle opens the next transaction at once.
               if (ap_start) begin
                  start_acc = 1'b1;
               end else begin
                  mod_state_d = IDLE;
               end
            end
         end
      endcase

      case (loop_state_q)
         LIDLE: begin
            if (loop_start) begin
               loop_state_d = LRUN;
            end
         end
         LRUN: begin
            // quit and loop_done together still close exactly one loop.
            if ((loop_done && loop_continue) || quit_ev) begin
               loop_end     = 1'b1;
               loop_state_d = LIDLE;
            end
         end
      endcase

      if (hold) begin
         mod_state_d    = mod_state_q;
         loop_state_d   = loop_state_q;
         last_latency_d = last_latency_q;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         mod_state_q    <= IDLE;
         loop_state_q   <= LIDLE;
         last_latency_q <= '0;
         frozen_q       <= 1'b0;
      end else begin
         mod_state_q    <= mod_state_d;
         loop_state_q   <= loop_state_d;
         last_latency_q <= last_latency_d;
         frozen_q       <= frozen_d;
      end
   end

   // The start cycle counts as busy, matching start-through-done latency.
   assign busy_now = (mod_state_q == BUSY) || start_acc;

   // In-flight latency counter is cleared on every accepted start.
   assign lat_clr = reset || (start_acc && !hold);

   // -------------------------------------------------------------- counters
   upc_sat_counter #(.CNT_W(CNT_W)) u_lat_cnt (
      .clock (clock),
      .reset (lat_clr),
      .inc   (mod_state_q == BUSY),
      .hold  (hold),
      .count (lat_cnt)
   );

   upc_sat_counter #(.CNT_W(CNT_W)) u_txn_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (txn_done),
      .hold  (hold),
      .count (txn_cnt)
   );

   upc_sat_counter #(.CNT_W(CNT_W)) u_busy_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (busy_now),
      .hold  (hold),
      .count (busy_cyc)
   );

   upc_sat_counter #(.CNT_W(CNT_W)) u_iter_start_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (iter_start_ev),
      .hold  (hold),
      .count (iter_start_cnt)
   );

   upc_sat_counter #(.CNT_W(CNT_W)) u_iter_end_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (iter_end_ev),
      .hold  (hold),
      .count (iter_end_cnt)
   );

   upc_sat_counter #(.CNT_W(CNT_W)) u_loop_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (loop_end),
      .hold  (hold),
      .count (loop_cnt)
   );

`ifdef UPC_MON_STALL_CNT_EN
   upc_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clock (clock),
      .reset (reset),
      .inc   ((loop_state_q == LRUN) && (iter_start_block || iter_end_block)),
      .hold  (hold),
      .count (stall_cyc)
   );
`endif

   // ---------------------------------------------------------------- status
   assign last_latency = last_latency_q;
   assign mod_busy     = (mod_state_q == BUSY);
   assign loop_active  = (loop_state_q == LRUN);
   assign frozen       = frozen_q;

endmodule : upc_loop_monitor

// File: tb/tb_upc_loop_monitor.sv
// -----------------------------------------------------------------------------
// tb_upc_loop_monitor
// Two monitors (CNT_W=32 and CNT_W=4) share one set of directed stimulus.
// A cycle-level behavioural model with unbounded counts predicts every output;
// saturation is applied when comparing. Hand-computed literals pin the model.
// -----------------------------------------------------------------------------
module tb_upc_loop_monitor;

   localparam int STATE_W = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset, finish;
   logic ap_start, ap_ready, ap_done, ap_continue;
   logic [STATE_W-1:0] cur_state, iter_start_state, iter_end_state, quit_state;
   logic iter_start_block, iter_end_block, quit_block;
   logic iter_start_enable, iter_end_enable, quit_enable;
   logic loop_start, loop_ready, loop_done, loop_continue, quit_at_end;

   logic [31:0] a_txn, a_busy, a_last, a_is, a_ie, a_loop, a_stall;
   logic        a_mbusy, a_lact, a_frz;
   logic [3:0]  b_txn, b_busy, b_last, b_is, b_ie, b_loop, b_stall;
   logic        b_mbusy, b_lact, b_frz;

   upc_loop_monitor #(.STATE_W(STATE_W)) dut_a (
      .clock(clk), .reset(reset), .finish(finish),
      .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
      .cur_state(cur_state), .iter_start_state(iter_start_state),
      .iter_end_state(iter_end_state), .quit_state(quit_state),
      .iter_start_block(iter_start_block), .iter_end_block(iter_end_block), .quit_block(quit_block),
      .iter_start_enable(iter_start_enable), .iter_end_enable(iter_end_enable), .quit_enable(quit_enable),
      .loop_start(loop_start), .loop_ready(loop_ready), .loop_done(loop_done),
      .loop_continue(loop_continue), .quit_at_end(quit_at_end),
      .txn_cnt(a_txn), .busy_cyc(a_busy), .last_latency(a_last),
      .iter_start_cnt(a_is), .iter_end_cnt(a_ie), .loop_cnt(a_loop),
`ifdef UPC_MON_STALL_CNT_EN
      .stall_cyc(a_stall),
`endif
      .mod_busy(a_mbusy), .loop_active(a_lact), .frozen(a_frz)
   );

   upc_loop_monitor #(.STATE_W(STATE_W), .CNT_W(4)) dut_b (
      .clock(clk), .reset(reset), .finish(finish),
      .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
      .cur_state(cur_state), .iter_start_state(iter_start_state),
      .iter_end_state(iter_end_state), .quit_state(quit_state),
      .iter_start_block(iter_start_block), .iter_end_block(iter_end_block), .quit_block(quit_block),
      .iter_start_enable(iter_start_enable), .iter_end_enable(iter_end_enable), .quit_enable(quit_enable),
      .loop_start(loop_start), .loop_ready(loop_ready), .loop_done(loop_done),
      .loop_continue(loop_continue), .quit_at_end(quit_at_end),
      .txn_cnt(b_txn), .busy_cyc(b_busy), .last_latency(b_last),
      .iter_start_cnt(b_is), .iter_end_cnt(b_ie), .loop_cnt(b_loop),
`ifdef UPC_MON_STALL_CNT_EN
      .stall_cyc(b_stall),
`endif
      .mod_busy(b_mbusy), .loop_active(b_lact), .frozen(b_frz)
   );

`ifndef UPC_MON_STALL_CNT_EN
   assign a_stall = '0;
   assign b_stall = '0;
`endif

   // ------------------------------------------------------------ scoreboard
   int pass_cnt  = 0;
   int total_cnt = 0;
   bit cmp_en    = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
   endtask

   function automatic logic [63:0] sat(input longint v, input int w);
      longint mx;
      mx = (longint'(1) << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   // ----------------------------------------------------- behavioural model
   // Counts are kept unbounded; a saturating counter equals min(count, max).
   longint m_txn = 0, m_busy = 0, m_last = 0, m_lat = 0;
   longint m_is = 0, m_ie = 0, m_loop = 0, m_stall = 0;
   bit     m_in_txn = 0, m_in_loop = 0, m_frozen = 0;
   bit     m_act, m_evs, m_eve, m_evq;

   always @(posedge clk) begin
      if (reset) begin
         m_txn = 0; m_busy = 0; m_last = 0; m_lat = 0;
         m_is = 0; m_ie = 0; m_loop = 0; m_stall = 0;
         m_in_txn = 0; m_in_loop = 0; m_frozen = 0;
      end else begin
         if (!m_frozen && !finish) begin
            // transaction: latency counts start cycle through done cycle
            if (m_in_txn) begin
               m_busy++;
               m_lat++;
               if (ap_done && ap_continue) begin
                  m_txn++;
                  m_last = m_lat;
                  if (ap_start) m_lat = 1;
                  else          m_in_txn = 0;
               end
            end else if (ap_start) begin
               m_in_txn = 1;
               m_busy++;
               m_lat = 1;
            end
            // loop
            m_act = m_in_loop || loop_start;
            m_evs = m_act && cur_state == iter_start_state && !iter_start_block && iter_start_enable;
            m_eve = m_act && cur_state == iter_end_state && !iter_end_block && iter_end_enable;
            m_evq = m_act && cur_state == quit_state && !quit_block && quit_enable && quit_at_end;
            if (m_evs) m_is++;
            if (m_eve) m_ie++;
            if (m_in_loop && (iter_start_block || iter_end_block)) m_stall++;
            if (m_in_loop) begin
               if ((loop_done && loop_continue) || m_evq) begin
                  m_in_loop = 0;
                  m_loop++;
               end
            end else if (loop_start) begin
               m_in_loop = 1;
            end
         end
         if (finish) m_frozen = 1;
      end
   end

   // compare every cycle once outputs are defined
   always @(negedge clk) begin
      if (cmp_en) begin
         check("txn_cnt",        a_txn,   sat(m_txn, 32));
         check("busy_cyc",       a_busy,  sat(m_busy, 32));
         check("last_latency",   a_last,  sat(m_last, 32));
         check("iter_start_cnt", a_is,    sat(m_is, 32));
         check("iter_end_cnt",   a_ie,    sat(m_ie, 32));
         check("loop_cnt",       a_loop,  sat(m_loop, 32));
         check("mod_busy",       a_mbusy, m_in_txn);
         check("loop_active",    a_lact,  m_in_loop);
         check("frozen",         a_frz,   m_frozen);
         check("w4_txn_cnt",        b_txn,   sat(m_txn, 4));
         check("w4_busy_cyc",       b_busy,  sat(m_busy, 4));
         check("w4_last_latency",   b_last,  sat(m_last, 4));
         check("w4_iter_start_cnt", b_is,    sat(m_is, 4));
         check("w4_iter_end_cnt",   b_ie,    sat(m_ie, 4));
         check("w4_loop_cnt",       b_loop,  sat(m_loop, 4));
         check("w4_mod_busy",       b_mbusy, m_in_txn);
         check("w4_loop_active",    b_lact,  m_in_loop);
         check("w4_frozen",         b_frz,   m_frozen);
`ifdef UPC_MON_STALL_CNT_EN
         check("stall_cyc",    a_stall, sat(m_stall, 32));
         check("w4_stall_cyc", b_stall, sat(m_stall, 4));
`endif
      end
   end

   // ------------------------------------------------------------- stimulus
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_inputs();
      finish = 0; ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 0;
      cur_state = 0; iter_start_state = 3; iter_end_state = 5; quit_state = 6;
      iter_start_block = 0; iter_end_block = 0; quit_block = 0;
      iter_start_enable = 0; iter_end_enable = 0; quit_enable = 0;
      loop_start = 0; loop_ready = 0; loop_done = 0; loop_continue = 0; quit_at_end = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1; cyc(1); reset = 0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_txn"},   a_txn,  0);
      check({tag, "_busy"},  a_busy, 0);
      check({tag, "_last"},  a_last, 0);
      check({tag, "_loop"},  a_loop, 0);
      check({tag, "_is"},    a_is,   0);
      check({tag, "_mbusy"}, a_mbusy, 0);
      check({tag, "_frz"},   a_frz,  0);
   endtask

   initial begin
      clear_inputs();
      reset = 1;
      cyc(2);
      cmp_en = 1;
      check_all_zero("lit_reset");
      reset = 0;

      // single transaction: start cycle 0, done cycle 4
      ap_start = 1; ap_continue = 1; cyc(1);
      ap_start = 0; ap_ready = 1; cyc(3);
      ap_done = 1; cyc(1);
      ap_done = 0; ap_ready = 0; cyc(1);
      check("lit_single_txn",   a_txn,   1);
      check("lit_single_lat",   a_last,  5);
      check("lit_single_busy",  a_busy,  5);
      check("lit_single_mbusy", a_mbusy, 0);

      // back-to-back: done and start in the same cycle
      do_reset();
      ap_start = 1; ap_continue = 1; cyc(1);
      ap_start = 0; cyc(2);
      for (int i = 1; i <= 3; i++) begin
         ap_start = 1; ap_done = 1; cyc(1);
         ap_start = 0; ap_done = 0; cyc(1);
         check("lit_b2b_mbusy", a_mbusy, 1);
         check("lit_b2b_txn",   a_txn,   i);
         check("lit_b2b_lat",   a_last,  (i == 1) ? 4 : 3);
      end
      ap_done = 1; cyc(1);
      ap_done = 0; cyc(1);
      check("lit_b2b_close", a_txn, 4);

      // loop with one blocked iteration
      do_reset();
      loop_start = 1; cyc(1);
      loop_start = 0; cur_state = 3; iter_start_enable = 1; cyc(2);
      iter_start_block = 1; cyc(1);
      iter_start_block = 0; cyc(1);
      cur_state = 0; iter_start_enable = 0;
      check("lit_loop_is",  a_is,   3);
      check("lit_loop_act", a_lact, 1);
      loop_done = 1; loop_continue = 1; cyc(1);
      loop_done = 0; loop_continue = 0;
      check("lit_loop_cnt",  a_loop, 1);
      check("lit_loop_idle", a_lact, 0);

      // first-cycle capture, simultaneous start/end, quit with done
      do_reset();
      iter_end_state = 3; cur_state = 3;
      iter_start_enable = 1; iter_end_enable = 1; loop_start = 1; cyc(1);
      loop_start = 0; cyc(1);
      quit_state = 3; quit_enable = 1; quit_at_end = 1;
      loop_done = 1; loop_continue = 1; cyc(1);
      clear_inputs(); cyc(1);
      check("lit_both_is",   a_is,   3);
      check("lit_both_ie",   a_ie,   3);
      check("lit_quit_once", a_loop, 1);
      loop_start = 1; cyc(1);
      loop_start = 0; cur_state = 6; quit_enable = 1; quit_at_end = 1; cyc(1);
      clear_inputs(); cyc(1);
      check("lit_quit_only", a_loop, 2);

      // matching states with the loop idle
      do_reset();
      iter_end_state = 3; cur_state = 3;
      iter_start_enable = 1; iter_end_enable = 1; cyc(3);
      check("lit_idle_is", a_is, 0);
      check("lit_idle_ie", a_ie, 0);

      // freeze mid-loop, mid-transaction
      do_reset();
      cur_state = 3; iter_start_enable = 1;
      ap_start = 1; loop_start = 1; cyc(1);
      ap_start = 0; loop_start = 0; cyc(1);
      finish = 1; cyc(1);
      finish = 0; ap_done = 1; ap_continue = 1; loop_done = 1; loop_continue = 1; ap_start = 1; cyc(3);
      check("lit_frz_flag", a_frz,   1);
      check("lit_frz_is",   a_is,    2);
      check("lit_frz_busy", a_busy,  2);
      check("lit_frz_txn",  a_txn,   0);
      check("lit_frz_loop", a_loop,  0);
      check("lit_frz_mb",   a_mbusy, 1);
      clear_inputs();
      finish = 1; reset = 1; cyc(1);
      finish = 0; reset = 0;
      check_all_zero("lit_frz_reset");

      // reset in the middle of a transaction discards it
      ap_start = 1; cyc(1);
      ap_start = 0; cyc(1);
      reset = 1; cyc(1);
      reset = 0; ap_done = 1; ap_continue = 1; cyc(1);
      clear_inputs(); cyc(1);
      check("lit_rst_mid_txn", a_txn, 0);

      // saturation on the narrow instance
      do_reset();
      for (int i = 0; i < 20; i++) begin
         ap_start = 1; ap_continue = 1; cyc(1);
         ap_start = 0; ap_done = 1; cyc(1);
         ap_done = 0;
      end
      cyc(1);
      check("lit_sat_txn_w4",  b_txn, 15);
      check("lit_sat_txn_w32", a_txn, 20);
      ap_start = 1; cyc(1);
      ap_start = 0; cyc(18);
      ap_done = 1; cyc(1);
      ap_done = 0; cyc(1);
      check("lit_sat_lat_w4",  b_last, 15);
      check("lit_sat_lat_w32", a_last, 20);
      for (int i = 0; i < 17; i++) begin
         loop_start = 1; cyc(1);
         loop_start = 0; loop_done = 1; loop_continue = 1; cyc(1);
         loop_done = 0; loop_continue = 0;
      end
      cyc(1);
      check("lit_sat_loop_w4", b_loop, 15);

      cyc(2);
      cmp_en = 0;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule : tb_upc_loop_monitor

// File: doc/upc_loop_monitor.md
UPC_LOOP_MONITOR -- requirements
Module: upc_loop_monitor

Interface
REQ-001 SHALL have parameter STATE_W, default 3, width of FSM state encodings.
REQ-002 SHALL have parameter CNT_W, default 32, width of every counter output.
REQ-003 SHALL have clock input, 1 bit; single clock, all logic on its rising edge.
REQ-004 SHALL have reset input, 1 bit; synchronous, active-high.
REQ-005 SHALL have finish input, 1 bit; end of observation, freezes all counters.
REQ-006 SHALL have ap_start, ap_ready, ap_done and ap_continue inputs, 1 bit each; module handshake being observed.
REQ-007 SHALL have cur_state, iter_start_state, iter_end_state and quit_state inputs, STATE_W bits each; loop FSM current state and the reference states.
REQ-008 SHALL have iter_start_block, iter_end_block and quit_block inputs, 1 bit each; stage subdone-block flags.
REQ-009 SHALL have iter_start_enable, iter_end_enable and quit_enable inputs, 1 bit each; pipeline enable registers.
REQ-010 SHALL have loop_start, loop_ready, loop_done, loop_continue and quit_at_end inputs, 1 bit each; loop handshake.
REQ-011 SHALL have outputs txn_cnt, busy_cyc, last_latency, iter_start_cnt, iter_end_cnt and loop_cnt, CNT_W bits each.
REQ-012 SHALL have outputs mod_busy, loop_active and frozen, 1 bit each.

Function
REQ-013 Module FSM states: IDLE and BUSY. IDLE->BUSY when ap_start=1. BUSY->IDLE when ap_done=1 and ap_continue=1.
REQ-014 txn_cnt SHALL increment by 1 on each BUSY->IDLE transition.
REQ-015 busy_cyc SHALL increment on every cycle in which the FSM is in BUSY. mod_busy SHALL equal (state==BUSY).
REQ-016 last_latency SHALL hold the number of BUSY cycles of the most recently completed transaction (start cycle through done cycle). Example: start at cycle 0, done at cycle 4 gives 5.
REQ-017 If ap_start=1 in the same cycle as BUSY->IDLE, the FSM SHALL go directly back to BUSY and start a new latency count. Back-to-back transactions are counted without gap.
REQ-018 iter_start event = (cur_state==iter_start_state) & ~iter_start_block & iter_start_enable & loop_active.
REQ-019 iter_end event = (cur_state==iter_end_state) & ~iter_end_block & iter_end_enable & loop_active.
REQ-020 quit event = (cur_state==quit_state) & ~quit_block & quit_enable & quit_at_end & loop_active.
REQ-021 Loop FSM states: LIDLE and LRUN. LIDLE->LRUN on loop_start. LRUN->LIDLE on (loop_done & loop_continue) or on a quit event. loop_active SHALL equal (state==LRUN) or loop_start=1 in LIDLE, so a first-cycle iteration is captured.
REQ-022 iter_start_cnt, iter_end_cnt and loop_cnt (+1 per LRUN->LIDLE) SHALL each increment by at most 1 per cycle.
REQ-023 Simultaneous iter_start and iter_end events in one cycle SHALL both be counted.
REQ-024 Simultaneous quit and loop_done SHALL count one loop only.
REQ-025 loop_ready is informational and SHALL NOT affect any state.
REQ-026 All counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-027 When finish=1 and reset=0, frozen SHALL set on the next edge and stay set. While frozen, no counter or FSM SHALL change.
REQ-028 A transaction or loop still open at freeze SHALL NOT be counted.
REQ-029 Outputs SHALL be registered, with 1-cycle latency from the triggering input edge.

Reset
REQ-030 On reset=1 at a clock edge: both FSMs go idle; all counters, last_latency, mod_busy, loop_active and frozen go to 0.
REQ-031 Reset SHALL override finish and any handshake in the same cycle.
REQ-032 Reset mid-transaction SHALL discard that transaction, which is not counted.

Configuration
REQ-033 With macro UPC_MON_STALL_CNT_EN defined, the block SHALL add output stall_cyc (CNT_W bits). stall_cyc counts cycles in LRUN where iter_start_block | iter_end_block is 1. It saturates, resets to 0, and freezes per REQ-027.
REQ-034 Without UPC_MON_STALL_CNT_EN, the stall_cyc port and its logic SHALL be absent.

Structure
REQ-035 Shared package upc_mon_pkg SHALL hold the enum typedefs for the module FSM (IDLE/BUSY) and loop FSM (LIDLE/LRUN), plus default parameter constants.
REQ-036 A single sub-module upc_sat_counter (parameter CNT_W; inputs clock, reset, inc, hold; output count) SHALL implement every saturating counter.

Verification
REQ-037 Reset, then ap_start=1 for 1 cycle with ap_done=1 four cycles later (ap_continue=1) -> txn_cnt=1, last_latency=5, busy_cyc=5, mod_busy=0.
REQ-038 ap_done and ap_start both high in the same cycle, repeated 3 times back-to-back -> txn_cnt=3, mod_busy stays 1 between transactions.
REQ-039 loop_start, then 4 cycles with cur_state==iter_start_state and enable=1, block=0, 1 of them blocked -> iter_start_cnt=3. Then loop_done -> loop_cnt=1, loop_active=0.
REQ-040 Iteration-matching states while loop is LIDLE -> iter_start_cnt and iter_end_cnt remain 0.
REQ-041 Mid-loop finish=1, then further events -> frozen=1 and all counters unchanged. A following reset clears all outputs to 0.
REQ-042 CNT_W=4, 20 transactions -> txn_cnt=15, with no wrap.
